// File: rtl/survivor_memory_rx.sv
// survivor_memory_rx: register-exchange survivor path memory for the Viterbi
// decoder. One decision bit per state per accepted trellis step. The decoded
// bit is taken from the oldest position of the selected survivor.
// Optional feature macro: SURVIVOR_BEST_STATE_EN. When it is defined, the
// decoded bit comes from the best_state survivor. When it is undefined, it
// always comes from state 0, which suits zero-terminated trellis decoding.
module survivor_memory_rx #(
  parameter int NUM_STATES = 4,
  parameter int DEPTH      = 12,
  localparam int SW        = $clog2(NUM_STATES),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  input  logic [NUM_STATES-1:0] dec,
  input  logic [SW-1:0]         best_state,
  output logic                  out_valid,
  output logic                  out_bit,
  output logic [CW-1:0]         fill
);

  // Fill state machine, encoded by the fill counter itself
  localparam logic [0:0] FILLING = 1'b0;
  localparam logic [0:0] STEADY  = 1'b1;

  logic [DEPTH-1:0] surv      [NUM_STATES];
  logic [DEPTH-1:0] surv_next [NUM_STATES];
  logic [SW-1:0]    sel;
  logic             cand;
  logic [0:0]       fill_state;

  assign fill_state = (fill == CW'(DEPTH)) ? STEADY : FILLING;

  // Register exchange: each state inherits its chosen predecessor's survivor, shifted, with its own input bit appended
  always_comb begin
    for (int unsigned n = 0; n < NUM_STATES; n++) begin
      logic [SW-1:0] p;
      p = SW'(n >> 1);
      if (dec[n])
        p = p + SW'(NUM_STATES / 2);
      surv_next[n] = {surv[p][DEPTH-2:0], n[0]};
    end
  end

`ifdef SURVIVOR_BEST_STATE_EN
  assign sel = best_state;
`else
  logic unused_best;
  assign unused_best = ^best_state;
  assign sel = '0;
`endif

  assign cand = surv_next[sel][DEPTH-1];

  // Survivor storage, fill counter and registered output
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned n = 0; n < NUM_STATES; n++)
        surv[n] <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else if (clear) begin
      for (int unsigned n = 0; n < NUM_STATES; n++)
        surv[n] <= '0;
      fill      <= '0;
      out_valid <= 1'b0;
      out_bit   <= 1'b0;
    end else if (in_valid) begin
      for (int unsigned n = 0; n < NUM_STATES; n++)
        surv[n] <= surv_next[n];
      out_bit   <= cand;
      out_valid <= (fill >= CW'(DEPTH - 1));
      if (fill_state == FILLING)
        fill <= fill + CW'(1);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/survivor_memory_rx.md
# survivor_memory_rx

Parametrised register-exchange survivor path memory for the Viterbi decoder. It generalises the fixed 4-state, fixed-depth path memory to any power-of-two state count and any traceback depth, and adds the following:
- an input valid qualifier and a synchronous clear;
- a fill counter;
- a single decoded-bit output with its own valid strobe.

It sits between the ACS array, which supplies one decision bit per state per trellis step, and the output bit sink.

## Interface
- NUM_STATES, 4: trellis states; power of two, ≥2. SW = clog2(NUM_STATES).
- DEPTH, 12: survivor length in bits (decoding delay); ≥2. CW = clog2(DEPTH+1).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous restart; empties the memory.
- in_valid  in  1  dec/best_state valid this cycle (one trellis step).
- dec  in  NUM_STATES  ACS decision per state; bit n = 1 selects the upper predecessor of state n.
- best_state  in  SW  index of the minimum-metric state for this step.
- out_valid  out  1  one-cycle strobe; out_bit is valid.
- out_bit  out  1  decoded bit.
- fill  out  CW  accepted steps since reset/clear, saturating at DEPTH.

## Operation
- **Trellis convention.**
  - Next state = ((s<<1)|u) mod NUM_STATES.
  - Predecessors of state n: lower = n>>1, upper = (n>>1)+NUM_STATES/2.
  - Input bit for state n = n[0].
- **Storage.** NUM_STATES survivor registers surv[n], each DEPTH bits. Bit 0 is the newest; bit DEPTH-1 is the oldest.
- **Accept (in_valid=1, clear=0).** All states update in parallel from pre-update values:
  - surv[n] ← {surv[pred(n)][DEPTH-2:0], n[0]}, where pred(n) = dec[n] ? upper : lower.
- **Output on accept.**
  - sel = best_state, or 0 (see Configuration).
  - Candidate bit = post-update surv[sel][DEPTH-1], computed combinationally from the new values.
  - out_bit ← candidate bit.
  - out_valid ← 1 if pre-update fill ≥ DEPTH-1, else 0.
  - fill ← min(fill+1, DEPTH).
- **Idle (in_valid=0, clear=0).**
  - surv, fill and out_bit hold.
  - out_valid ← 0.
- **clear=1.**
  - surv all ← 0, fill ← 0, out_valid ← 0, out_bit ← 0.
  - clear has priority over a simultaneous in_valid; that step is dropped.
- **Fill state machine** (encoded by fill):
  - FILLING (fill < DEPTH) → STEADY when fill reaches DEPTH.
  - STEADY → FILLING only on clear or reset.
  - In STEADY, every accept produces exactly one out_valid.
- **Valid input range.** best_state ≥ NUM_STATES cannot occur for power-of-two NUM_STATES; no check is required.

## Timing
- **Reset values** (reset low, immediately and asynchronously): surv = 0, fill = 0, out_valid = 0, out_bit = 0.
- **Reset release.** Deassertion is synchronised externally. The first edge with reset high is a normal edge.
- **Reset mid-operation.** All state is lost. Behaviour after release is identical to power-up.
- **Output latency.**
  - out_valid/out_bit are registered and appear on the same edge that accepts the step.
  - The first out_valid coincides with the DEPTH-th accept after reset/clear.
  - That bit is the u decided at accept 1 along the selected survivor; decoding delay = DEPTH-1 steps.
- **Throughput.** One step per cycle; back-to-back in_valid is supported. No backpressure: the sink must take every out_valid.
- **Gaps.** Gaps in in_valid do not change the survivors or the output sequence; they only stretch it in time.

## Configuration
- **SURVIVOR_BEST_STATE_EN defined:** sel = best_state (best-state decoding).
- **SURVIVOR_BEST_STATE_EN undefined:** sel = 0 constant (zero-terminated trellis decoding). best_state is present but ignored, and its selection mux is not built.

## Test plan
All scenarios use NUM_STATES=4, DEPTH=12.
- **Reset.** Assert reset mid-stream with in_valid=1 → out_valid=0, out_bit=0 and fill=0 immediately. After release, the first out_valid comes on the 12th accept.
- **All-zero fill.** 12 accepts of dec=4'b0000, best_state=0 → fill counts 1..12. out_valid is low on accepts 1–11 and high on accept 12 with out_bit=0. Accept 13 gives out_valid=1, out_bit=0, fill=12.
- **Configuration macro.** 12 accepts of dec=4'b1010, best_state=3 → surv[3]=12'hFFF and surv[0]=12'h000.
  - With SURVIVOR_BEST_STATE_EN: out_bit=1 on accept 12.
  - Without it: out_bit=0 on accept 12.
- **Gapped input.** Same stimulus as the all-zero fill, with in_valid low on every other cycle → identical out_valid/out_bit sequence per accept; out_valid is never high on idle cycles.
- **Clear.** clear=1 together with in_valid=1 at fill=7 → step dropped, fill=0. The next out_valid comes only after 12 further accepts.
- **Steady state vs. reference model.** Random dec/best_state for 500 accepts, compared bit-exactly with a software register-exchange model → one out_valid per accept from accept 12 onward, and out_bit matches the model on every one.
